sd_cmd_responder: RTL and testbench
===================================

SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 SHALL have parameter NCR, default 2, meaning idle cycles between response accept and response start bit (legal range 2..63).
REQ-002 SHALL have parameter RESP_WAIT, default 64, meaning cycles allowed for the user response after ocmd_valid.
REQ-003 iclk  input  1  system clock; one CMD bit is sampled or driven per iclk cycle.
REQ-004 irst  input  1  reset, asynchronous, active-low.
REQ-005 icmd_sd  input  1  CMD line from host.
REQ-006 ocmd_sd  output  1  CMD line value driven to host.
REQ-007 ocmd_sd_en  output  1  CMD output enable; line released when low.
REQ-008 ocmd_valid  output  1  one-cycle pulse: command received and accepted.
REQ-009 ocmd_index  output  6  index of the last accepted command.
REQ-010 ocmd_arg  output  32  argument of the last accepted command.
REQ-011 ocrc_fail  output  1  one-cycle pulse: CRC7 mismatch or end bit 0.
REQ-012 iresp_valid  input  1  user supplies response, sampled only in WAIT_RESP.
REQ-013 iresp_skip  input  1  user declines to respond (e.g. CMD0), sampled only in WAIT_RESP.
REQ-014 iresp_index  input  6  response index field.
REQ-015 iresp_arg  input  32  response payload (card status / echo).
REQ-016 ono_resp  output  1  one-cycle pulse: RESP_WAIT expired.
REQ-017 obusy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, RX, WAIT_RESP, NCR_GAP and TX.
REQ-019 IDLE: icmd_sd==0 SHALL enter RX; the next bit (transmission bit) SHALL be 1, else the frame is silently dropped and the FSM returns to IDLE.
REQ-020 RX SHALL shift in the 48-bit frame: start bit, transmission bit, index[5:0], arg[31:0], CRC7, end bit, with MSB first.
REQ-021 CRC7 (x^7+x^3+1, init 0) SHALL cover the first 40 bits.
REQ-022 One cycle after the end bit is sampled, the block SHALL either pulse ocmd_valid, latch ocmd_index/ocmd_arg and enter WAIT_RESP, or pulse ocrc_fail and enter IDLE.
REQ-023 WAIT_RESP: iresp_valid SHALL latch iresp_index/iresp_arg and enter NCR_GAP; iresp_skip SHALL enter IDLE; if both are asserted, iresp_skip SHALL win.
REQ-024 iresp_valid asserted in the same cycle as ocmd_valid SHALL be accepted.
REQ-025 WAIT_RESP SHALL count RESP_WAIT cycles; on expiry it SHALL pulse ono_resp and enter IDLE, with ocmd_sd_en never asserted.
REQ-026 The start bit SHALL appear on ocmd_sd, with ocmd_sd_en=1, exactly NCR+1 cycles after the iresp_valid sample cycle.
REQ-027 TX SHALL drive 48 bits: 0, 0 (card transmission bit), iresp_index, iresp_arg, CRC7, 1.
REQ-028 ocmd_sd_en SHALL drop in the cycle after the end bit, and the FSM SHALL return to IDLE.
REQ-029 icmd_sd SHALL be ignored in WAIT_RESP, NCR_GAP and TX.
REQ-030 iresp_* SHALL be ignored outside WAIT_RESP.
REQ-031 ocmd_sd SHALL be 1 whenever ocmd_sd_en is 0.

Reset
REQ-032 irst low SHALL asynchronously force IDLE, ocmd_sd_en=0, ocmd_sd=1, all pulses 0, ocmd_index=0, ocmd_arg=0, obusy=0 and all counters 0.
REQ-033 Reset mid-TX SHALL release the line immediately; no partial frame is resumed after reset.

Configuration
REQ-034 With SD_CMD_CRC_CHECK_EN defined, a received-CRC mismatch SHALL produce ocrc_fail per REQ-022.
REQ-035 Without SD_CMD_CRC_CHECK_EN, the received CRC SHALL be ignored, only end bit 0 SHALL raise ocrc_fail, and response CRC generation is unaffected.

Structure
REQ-036 Package sd_pkg SHALL hold the frame length 48, CRC7 polynomial 7'h09, the state enum, and the field offsets.
REQ-037 One sub-module, crc7, SHALL implement the serial CRC7 with clear/enable and SHALL be instantiated for both RX and TX.

Verification
REQ-038 CMD0 frame 0x400000000095 -> ocmd_valid, index 0, arg 0; then iresp_skip -> IDLE, no drive.
REQ-039 CMD8 0x48000001AA87, then iresp_index 8, iresp_arg 0x000001AA -> frame 0x08000001AA13 on ocmd_sd, start bit NCR+1 cycles after accept.
REQ-040 CMD0 with CRC byte 0x97 -> ocrc_fail pulse and no ocmd_valid; with the macro undefined -> ocmd_valid.
REQ-041 Valid CMD55 with no response for 64 cycles -> ono_resp pulse in cycle 64, ocmd_sd_en stays 0.
REQ-042 Frame with transmission bit 0 -> no pulses, IDLE; irst low at TX bit 20 -> ocmd_sd_en=0 the same cycle.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD CMD-line responder.
//   - frame geometry (48-bit command/response frame, 40 CRC-covered bits)
//   - CRC7 polynomial (x^7 + x^3 + 1) and a single-step serial CRC helper
//   - FSM state encoding
//   - field offsets inside a received frame held as [45:0] (the start and
//     transmission bits are not kept, so bit 0 is the end bit)
package sd_pkg;

  localparam int FRAME_LEN = 48;
  localparam int CRC_COVER = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int OFF_INDEX = 40;  // [45:40]
  localparam int OFF_ARG   = 8;   // [39:8]
  localparam int OFF_CRC   = 1;   // [7:1]
  localparam int OFF_END   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_WAIT_RESP,
    ST_NCR_GAP,
    ST_TX
  } sd_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_responder_crc7.sv
// crc7: serial CRC7 (x^7 + x^3 + 1, init 0), one bit per iclk.
// Ports:
//   iclk, irst  clock / async active-low reset
//   clr         restart the CRC from 0
//   en          fold din into the CRC this cycle (with clr: fold into 0)
//   din         serial data bit
//   crc         CRC including this cycle's din when en is high; equals the
//               stored value when en and clr are low
import sd_pkg::*;

module crc7 (
  input  logic       iclk,
  input  logic       irst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;

  // Exposing the next value lets the transmitter emit the first CRC bit
  // in the same cycle the last covered bit is folded in.
  always_comb begin
    crc = crc_q;
    if (en)
      crc = crc7_step(clr ? 7'h00 : crc_q, din);
    else if (clr)
      crc = 7'h00;
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst)
      crc_q <= 7'h00;
    else
      crc_q <= crc;
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: SD card-side CMD line engine. Receives a 48-bit host
// command, hands index/argument to the user, then transmits the user's
// 48-bit response after an NCR gap.
// Build option: SD_CMD_CRC_CHECK_EN -- when defined, a received CRC7
// mismatch raises ocrc_fail; otherwise only a 0 end bit does.
// Parameters: NCR (idle cycles before response start, 2..63),
//             RESP_WAIT (cycles the user has to respond).
// Ports:
//   iclk, irst                 clock / async active-low reset
//   icmd_sd                    CMD line from host
//   ocmd_sd, ocmd_sd_en        CMD drive value / enable (1 when released)
//   ocmd_valid, ocmd_index,
//   ocmd_arg                   accepted-command pulse and fields
//   ocrc_fail                  pulse: bad CRC or end bit
//   iresp_valid, iresp_skip,
//   iresp_index, iresp_arg     user response handshake (WAIT_RESP only)
//   ono_resp                   pulse: response window expired
//   obusy                      FSM not idle
//
// state        | meaning
// ST_IDLE      | watching for a start bit
// ST_RX        | shifting in the 47 bits after the start bit
// ST_WAIT_RESP | command accepted, waiting for user response or skip
// ST_NCR_GAP   | NCR idle cycles before the response start bit
// ST_TX        | driving the 48-bit response
import sd_pkg::*;

module sd_cmd_responder #(
  parameter int NCR       = 2,
  parameter int RESP_WAIT = 64
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        icmd_sd,
  output logic        ocmd_sd,
  output logic        ocmd_sd_en,
  output logic        ocmd_valid,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  output logic        ocrc_fail,
  input  logic        iresp_valid,
  input  logic        iresp_skip,
  input  logic [5:0]  iresp_index,
  input  logic [31:0] iresp_arg,
  output logic        ono_resp,
  output logic        obusy
);

  localparam int WAIT_W = $clog2(RESP_WAIT + 1);

  sd_state_e         state;
  logic [44:0]       rx_shift;
  logic [45:0]       rx_frame;
  logic [5:0]        bit_cnt;
  logic [5:0]        tx_cnt;
  logic [5:0]        gap_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [39:0]       tx_shift;
  logic [6:0]        rx_crc;
  logic [6:0]        tx_crc;
  logic [2:0]        crc_sel;
  logic              rx_crc_clr, rx_crc_en;
  logic              tx_crc_clr, tx_crc_en;
  logic              frame_ok;

  // Frame as it stands at the edge sampling the end bit.
  assign rx_frame = {rx_shift, icmd_sd};

  assign rx_crc_clr = (state == ST_IDLE);
  assign rx_crc_en  = ((state == ST_IDLE) && !icmd_sd) ||
                      ((state == ST_RX) && (bit_cnt < 6'(CRC_COVER)));
  assign tx_crc_clr = (state == ST_WAIT_RESP);
  assign tx_crc_en  = (state == ST_TX) && (tx_cnt < 6'(CRC_COVER));

  crc7 u_rx_crc (
    .iclk (iclk),
    .irst (irst),
    .clr  (rx_crc_clr),
    .en   (rx_crc_en),
    .din  (icmd_sd),
    .crc  (rx_crc)
  );

  // The bit currently on the line is what gets folded into the response CRC.
  crc7 u_tx_crc (
    .iclk (iclk),
    .irst (irst),
    .clr  (tx_crc_clr),
    .en   (tx_crc_en),
    .din  (ocmd_sd),
    .crc  (tx_crc)
  );

`ifdef SD_CMD_CRC_CHECK_EN
  assign frame_ok = rx_frame[OFF_END] && (rx_frame[OFF_CRC+6:OFF_CRC] == rx_crc);
`else
  logic rx_crc_unused;
  assign rx_crc_unused = ^{rx_crc, rx_frame[OFF_CRC+6:OFF_CRC]};
  assign frame_ok = rx_frame[OFF_END];
`endif

  // Next CRC bit to drive when bit tx_cnt+1 lies in 40..46.
  assign crc_sel = 3'(6'd45 - tx_cnt);

  assign obusy = (state != ST_IDLE);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state      <= ST_IDLE;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      tx_cnt     <= '0;
      gap_cnt    <= '0;
      wait_cnt   <= '0;
      tx_shift   <= '0;
      ocmd_sd    <= 1'b1;
      ocmd_sd_en <= 1'b0;
      ocmd_valid <= 1'b0;
      ocmd_index <= '0;
      ocmd_arg   <= '0;
      ocrc_fail  <= 1'b0;
      ono_resp   <= 1'b0;
    end else begin
      ocmd_valid <= 1'b0;
      ocrc_fail  <= 1'b0;
      ono_resp   <= 1'b0;
      case (state)
        ST_IDLE: begin
          rx_shift <= {rx_shift[43:0], icmd_sd};
          if (!icmd_sd) begin
            state   <= ST_RX;
            bit_cnt <= 6'd1;
          end
        end
        ST_RX: begin
          rx_shift <= {rx_shift[43:0], icmd_sd};
          bit_cnt  <= bit_cnt + 6'd1;
          if ((bit_cnt == 6'd1) && !icmd_sd) begin
            state <= ST_IDLE;
          end else if (bit_cnt == 6'(FRAME_LEN - 1)) begin
            if (frame_ok) begin
              ocmd_valid <= 1'b1;
              ocmd_index <= rx_frame[OFF_INDEX+5:OFF_INDEX];
              ocmd_arg   <= rx_frame[OFF_ARG+31:OFF_ARG];
              wait_cnt   <= WAIT_W'(RESP_WAIT - 1);
              state      <= ST_WAIT_RESP;
            end else begin
              ocrc_fail <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (iresp_skip) begin
            state <= ST_IDLE;
          end else if (iresp_valid) begin
            tx_shift <= {2'b00, iresp_index, iresp_arg};
            gap_cnt  <= 6'(NCR - 1);
            state    <= ST_NCR_GAP;
          end else if (wait_cnt == '0) begin
            ono_resp <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_NCR_GAP: begin
          if (gap_cnt == '0) begin
            ocmd_sd_en <= 1'b1;
            ocmd_sd    <= tx_shift[39];
            tx_shift   <= {tx_shift[38:0], 1'b0};
            tx_cnt     <= '0;
            state      <= ST_TX;
          end else begin
            gap_cnt <= gap_cnt - 6'd1;
          end
        end
        ST_TX: begin
          tx_cnt <= tx_cnt + 6'd1;
          if (tx_cnt < 6'd39) begin
            ocmd_sd  <= tx_shift[39];
            tx_shift <= {tx_shift[38:0], 1'b0};
          end else if (tx_cnt < 6'd46) begin
            ocmd_sd <= tx_crc[crc_sel];
          end else if (tx_cnt == 6'd46) begin
            ocmd_sd <= 1'b1;
          end else begin
            ocmd_sd_en <= 1'b0;
            ocmd_sd    <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb_sd_cmd_responder: directed bench for sd_cmd_responder with
// hand-computed frames (CMD0, CMD8/R7, CMD55, bad CRC, bad end bit,
// transmission bit 0, reset during response).
module tb_sd_cmd_responder;

  localparam int NCR       = 2;
  localparam int RESP_WAIT = 64;

  logic        iclk = 1'b0;
  logic        irst = 1'b0;
  logic        icmd_sd = 1'b1;
  logic        ocmd_sd, ocmd_sd_en, ocmd_valid, ocrc_fail, ono_resp, obusy;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic        iresp_valid = 1'b0;
  logic        iresp_skip = 1'b0;
  logic [5:0]  iresp_index = '0;
  logic [31:0] iresp_arg = '0;

  int total = 0;
  int bad = 0;

  sd_cmd_responder #(.NCR(NCR), .RESP_WAIT(RESP_WAIT)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .icmd_sd     (icmd_sd),
    .ocmd_sd     (ocmd_sd),
    .ocmd_sd_en  (ocmd_sd_en),
    .ocmd_valid  (ocmd_valid),
    .ocmd_index  (ocmd_index),
    .ocmd_arg    (ocmd_arg),
    .ocrc_fail   (ocrc_fail),
    .iresp_valid (iresp_valid),
    .iresp_skip  (iresp_skip),
    .iresp_index (iresp_index),
    .iresp_arg   (iresp_arg),
    .ono_resp    (ono_resp),
    .obusy       (obusy)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      icmd_sd = f[i];
      tick();
    end
    icmd_sd = 1'b1;
  endtask

  logic [47:0] cap;
  logic        seen_en, seen_pulse, en_all;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_sd_en", ocmd_sd_en, 1'b0);
    chk("rst_sd", ocmd_sd, 1'b1);
    chk("rst_busy", obusy, 1'b0);
    chk("rst_index", ocmd_index, 6'd0);
    chk("rst_arg", ocmd_arg, 32'd0);
    chk("rst_pulses", {ocmd_valid, ocrc_fail, ono_resp}, 3'b000);
    irst = 1'b1;
    repeat (2) tick();

    // Response inputs outside WAIT_RESP are ignored
    iresp_valid = 1'b1;
    repeat (3) tick();
    iresp_valid = 1'b0;
    chk("idle_resp_ignored_busy", obusy, 1'b0);
    chk("idle_resp_ignored_en", ocmd_sd_en, 1'b0);

    // CMD0, then skip
    send_frame(48'h400000000095);
    chk("cmd0_valid", ocmd_valid, 1'b1);
    chk("cmd0_crcfail", ocrc_fail, 1'b0);
    chk("cmd0_index", ocmd_index, 6'd0);
    chk("cmd0_arg", ocmd_arg, 32'd0);
    chk("cmd0_busy", obusy, 1'b1);
    iresp_skip = 1'b1;
    tick();
    iresp_skip = 1'b0;
    chk("cmd0_skip_idle", obusy, 1'b0);
    seen_en = 1'b0;
    repeat (10) begin
      tick();
      seen_en |= ocmd_sd_en;
    end
    chk("cmd0_no_drive", seen_en, 1'b0);

    // CMD8, respond with R7 accepted in the ocmd_valid cycle
    send_frame(48'h48000001AA87);
    chk("cmd8_valid", ocmd_valid, 1'b1);
    chk("cmd8_index", ocmd_index, 6'd8);
    chk("cmd8_arg", ocmd_arg, 32'h000001AA);
    iresp_valid = 1'b1;
    iresp_index = 6'd8;
    iresp_arg   = 32'h000001AA;
    tick();  // accept edge; now in cycle accept+1
    iresp_valid = 1'b0;
    iresp_index = 6'd63;
    iresp_arg   = 32'hDEADBEEF;
    icmd_sd     = 1'b0;  // must be ignored during the gap
    chk("cmd8_valid_one_cycle", ocmd_valid, 1'b0);
    chk("cmd8_gap1_en", ocmd_sd_en, 1'b0);
    tick();
    chk("cmd8_gap2_en", ocmd_sd_en, 1'b0);
    icmd_sd = 1'b1;
    tick();  // accept+NCR+1
    chk("cmd8_start_en", ocmd_sd_en, 1'b1);
    chk("cmd8_start_bit", ocmd_sd, 1'b0);
    en_all = 1'b1;
    for (int i = 47; i >= 0; i--) begin
      cap[i] = ocmd_sd;
      en_all &= ocmd_sd_en;
      tick();
    end
    chk("cmd8_resp_frame", cap, 48'h08000001AA13);
    chk("cmd8_en_held", en_all, 1'b1);
    chk("cmd8_release_en", ocmd_sd_en, 1'b0);
    chk("cmd8_release_sd", ocmd_sd, 1'b1);
    chk("cmd8_release_busy", obusy, 1'b0);

    // CMD0 with CRC byte 0x97
    send_frame(48'h400000000097);
`ifdef SD_CMD_CRC_CHECK_EN
    chk("badcrc_crcfail", ocrc_fail, 1'b1);
    chk("badcrc_valid", ocmd_valid, 1'b0);
    chk("badcrc_busy", obusy, 1'b0);
`else
    chk("badcrc_crcfail", ocrc_fail, 1'b0);
    chk("badcrc_valid", ocmd_valid, 1'b1);
    iresp_skip = 1'b1;
    tick();
    iresp_skip = 1'b0;
    chk("badcrc_skip_idle", obusy, 1'b0);
`endif
    tick();
    chk("badcrc_pulse_clear", {ocrc_fail, ocmd_valid}, 2'b00);

    // End bit 0 fails in every build
    send_frame(48'h400000000094);
    chk("endbit_crcfail", ocrc_fail, 1'b1);
    chk("endbit_valid", ocmd_valid, 1'b0);
    chk("endbit_busy", obusy, 1'b0);
    repeat (2) tick();

    // CMD55 with no response: ono_resp 64 cycles after ocmd_valid
    send_frame(48'h770000000065);
    chk("cmd55_valid", ocmd_valid, 1'b1);
    chk("cmd55_index", ocmd_index, 6'd55);
    seen_pulse = 1'b0;
    seen_en    = 1'b0;
    for (int k = 1; k < RESP_WAIT; k++) begin
      tick();
      seen_pulse |= ono_resp;
      seen_en    |= ocmd_sd_en;
    end
    chk("cmd55_no_early_timeout", seen_pulse, 1'b0);
    tick();
    chk("cmd55_noresp_pulse", ono_resp, 1'b1);
    chk("cmd55_noresp_idle", obusy, 1'b0);
    seen_en |= ocmd_sd_en;
    tick();
    chk("cmd55_noresp_one_cycle", ono_resp, 1'b0);
    chk("cmd55_never_drove", seen_en, 1'b0);

    // Both valid and skip: skip wins
    send_frame(48'h400000000095);
    chk("both_valid", ocmd_valid, 1'b1);
    iresp_valid = 1'b1;
    iresp_skip  = 1'b1;
    tick();
    iresp_valid = 1'b0;
    iresp_skip  = 1'b0;
    chk("both_skip_wins", obusy, 1'b0);
    seen_en = 1'b0;
    repeat (6) begin
      tick();
      seen_en |= ocmd_sd_en;
    end
    chk("both_no_drive", seen_en, 1'b0);

    // Transmission bit 0: silently dropped
    seen_pulse = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      icmd_sd = (i >= 46) ? 1'b0 : 1'b1;
      tick();
      seen_pulse |= ocmd_valid | ocrc_fail | ono_resp;
    end
    icmd_sd = 1'b1;
    repeat (5) begin
      tick();
      seen_pulse |= ocmd_valid | ocrc_fail | ono_resp;
    end
    chk("tbit0_no_pulses", seen_pulse, 1'b0);
    chk("tbit0_idle", obusy, 1'b0);

    // Reset at response bit 20
    send_frame(48'h48000001AA87);
    iresp_valid = 1'b1;
    iresp_index = 6'd8;
    iresp_arg   = 32'h000001AA;
    tick();
    iresp_valid = 1'b0;
    repeat (NCR) tick();  // start bit on the line
    repeat (20) tick();   // bit 20 on the line
    chk("midtx_en_before", ocmd_sd_en, 1'b1);
    irst = 1'b0;
    #1;
    chk("midtx_en_async", ocmd_sd_en, 1'b0);
    chk("midtx_sd_async", ocmd_sd, 1'b1);
    chk("midtx_busy_async", obusy, 1'b0);
    tick();
    irst = 1'b1;
    seen_en = 1'b0;
    repeat (30) begin
      tick();
      seen_en |= ocmd_sd_en;
    end
    chk("midtx_no_resume", seen_en, 1'b0);
    chk("midtx_index_cleared", ocmd_index, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
